matrix_parser: RTL and testbench
================================

MATRIX_PARSER -- requirements
Module: matrix_parser

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 Parameter: MAX_DIM, default 5, largest legal row/column count (1..5); element count SHALL NOT exceed 25.
REQ-003 clk  input  1  system clock, all state on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  one-cycle pulse that begins (or restarts) a parse.
REQ-006 busy  output  1  high from the cycle after start until done or error.
REQ-007 rx_data  input  8  received byte from the UART RX.
REQ-008 rx_valid  input  1  one-cycle strobe qualifying rx_data.
REQ-009 matrix_row  output  3  row count of the last successfully parsed matrix.
REQ-010 matrix_col  output  3  column count of the last successfully parsed matrix.
REQ-011 wr_en  output  1  one-cycle storage write strobe.
REQ-012 wr_addr  output  5  row-major element index, r*matrix_col+c.
REQ-013 wr_data  output  8  element value.
REQ-014 done  output  1  one-cycle pulse: matrix fully received.
REQ-015 error  output  1  one-cycle pulse: parse aborted.
REQ-016 err_code  output  2  0 none, 1 BAD_CHAR, 2 BAD_DIM, 3 OVERFLOW; held until next start.

Function
REQ-017 Input stream format: "R C e0 e1 ... e(R*C-1)", decimal ASCII tokens separated by space (0x20), CR (0x0D) or LF (0x0A).
REQ-018 States: IDLE, GET_ROW, GET_COL, GET_ELEM, DONE, ERROR; start moves any state to GET_ROW with accumulator, digit flag and element counter cleared, and err_code set to 0.
REQ-019 In IDLE, DONE and ERROR, rx_valid bytes SHALL be ignored.
REQ-020 Digit '0'..'9': acc <= acc*10 + digit, computed at 9+ bits; a result > 255 SHALL give OVERFLOW.
REQ-021 Separator with at least one digit pending terminates the token; separators with no pending digit (leading or repeated) SHALL be ignored.
REQ-022 Any other byte in a GET_* state SHALL give BAD_CHAR.
REQ-023 GET_ROW/GET_COL token value outside 1..MAX_DIM SHALL give BAD_DIM; otherwise it is latched internally and the FSM advances to GET_COL/GET_ELEM.
REQ-024 GET_ELEM token: on the cycle after the terminating rx_valid, wr_en=1, wr_addr=element counter, wr_data=acc[7:0]; the counter then increments.
REQ-025 When the written element is index R*C-1: done=1 on the same cycle as that wr_en, matrix_row/matrix_col updated to R/C, FSM to DONE then IDLE, and busy low from the next cycle.
REQ-026 Error path: error=1 and err_code set on the cycle after the offending rx_valid, no further wr_en, FSM to ERROR then IDLE, busy low next cycle; matrix_row/matrix_col unchanged.
REQ-027 start together with rx_valid: start wins and the byte is discarded.
REQ-028 start while busy aborts the current parse without error; elements already written are not retracted.
REQ-029 wr_en, done and error SHALL each be high for exactly one cycle per event and never together except done with the final wr_en.
REQ-030 Line end without the full element count SHALL NOT complete the parse; only the element count terminates it.

Reset
REQ-031 On rst_n low, all outputs SHALL go to 0 asynchronously (busy, wr_en, wr_addr, wr_data, done, error, err_code, matrix_row, matrix_col) and the FSM SHALL go to IDLE; reset mid-parse discards all progress.

Verification
REQ-032 start, "2 3 1 2 3 4 5 6\n" -> six wr_en, addr 0..5, data 1..6; done with the last write; matrix_row=2, matrix_col=3; busy low after.
REQ-033 start, "  1  1  255 " -> one wr_en addr 0 data 0xFF, done. Then start, "1 1 256 " -> error, err_code=3, no wr_en, dims stay 1/1.
REQ-034 start, "0 " -> error err_code=2. Also "6 " -> err_code=2. Also "2 6 " -> err_code=2.
REQ-035 start, "2 x" -> error err_code=1 one cycle after 'x'. Bytes afterward produce no output.
REQ-036 start, "2 2 7 8 ", then start, "1 2 3 4 " -> writes (0,7),(1,8), then (0,3),(1,4); done; dims 1/2; no error.
REQ-037 rst_n pulsed low mid-element -> all outputs 0 immediately. Subsequent bytes ignored until start.

Source files
------------

// File: rtl/matrix_parser.sv
// Parses a decimal ASCII stream "R C e0 .. e(R*C-1)" arriving from a UART RX
// into row-major element writes, with character, dimension and overflow checks.
module matrix_parser #(
  parameter int MAX_DIM = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       busy,
  output logic [2:0] matrix_row,
  output logic [2:0] matrix_col,
  output logic       wr_en,
  output logic [4:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code,
  output logic [2:0] state_dbg
);

  // Handshake: rx_valid is a one-cycle strobe with no back-pressure, so every
  // qualified byte is consumed in the cycle it arrives; wr_en is likewise a
  // one-cycle strobe that the element storage must accept unconditionally.

  typedef enum logic [2:0] {
    IDLE,
    GET_ROW,
    GET_COL,
    GET_ELEM,
    DONE,
    ERROR
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_BAD_CHAR = 2'd1;
  localparam logic [1:0] ERR_BAD_DIM  = 2'd2;
  localparam logic [1:0] ERR_OVERFLOW = 2'd3;
  localparam logic [7:0] MAX_DIM_B    = 8'(MAX_DIM);

  state_t     state, state_n;
  logic [7:0] acc, acc_n;
  logic       pend, pend_n;
  logic [2:0] dim_r, dim_r_n;
  logic [2:0] dim_c, dim_c_n;
  logic [4:0] cnt, cnt_n;
  logic       busy_n;
  logic       wr_en_n;
  logic [4:0] wr_addr_n;
  logic [7:0] wr_data_n;
  logic       done_n;
  logic       error_n;
  logic [1:0] err_code_n;
  logic [2:0] mrow_n, mcol_n;
  logic       fault;
  logic [1:0] fault_code;

  logic        is_digit;
  logic        is_sep;
  logic [11:0] acc_ext;
  logic        dim_ok;
  logic [4:0]  total;
  logic        last_elem;

  // Accumulate at 12 bits so any single digit step past 255 is visible.
  assign is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign is_sep    = (rx_data == 8'h20) || (rx_data == 8'h0D) || (rx_data == 8'h0A);
  assign acc_ext   = ({4'd0, acc} * 12'd10) + {8'd0, rx_data[3:0]};
  assign dim_ok    = (acc != 8'd0) && (acc <= MAX_DIM_B);
  assign total     = 5'(dim_r) * 5'(dim_c);
  assign last_elem = (cnt == (total - 5'd1));
  assign state_dbg = state;

  always_comb begin
    state_n    = state;
    acc_n      = acc;
    pend_n     = pend;
    dim_r_n    = dim_r;
    dim_c_n    = dim_c;
    cnt_n      = cnt;
    wr_en_n    = 1'b0;
    wr_addr_n  = wr_addr;
    wr_data_n  = wr_data;
    done_n     = 1'b0;
    error_n    = 1'b0;
    err_code_n = err_code;
    mrow_n     = matrix_row;
    mcol_n     = matrix_col;
    fault      = 1'b0;
    fault_code = ERR_NONE;

    if (start) begin
      // start wins over a coincident byte and silently abandons any parse
      state_n    = GET_ROW;
      acc_n      = 8'd0;
      pend_n     = 1'b0;
      cnt_n      = 5'd0;
      err_code_n = ERR_NONE;
    end else begin
      case (state)
        DONE, ERROR: state_n = IDLE;
        GET_ROW, GET_COL, GET_ELEM: begin
          if (rx_valid) begin
            if (is_digit) begin
              if (acc_ext > 12'd255) begin
                fault      = 1'b1;
                fault_code = ERR_OVERFLOW;
              end else begin
                acc_n  = acc_ext[7:0];
                pend_n = 1'b1;
              end
            end else if (is_sep) begin
              if (pend) begin
                acc_n  = 8'd0;
                pend_n = 1'b0;
                if (state == GET_ROW) begin
                  if (dim_ok) begin
                    dim_r_n = acc[2:0];
                    state_n = GET_COL;
                  end else begin
                    fault      = 1'b1;
                    fault_code = ERR_BAD_DIM;
                  end
                end else if (state == GET_COL) begin
                  if (dim_ok) begin
                    dim_c_n = acc[2:0];
                    cnt_n   = 5'd0;
                    state_n = GET_ELEM;
                  end else begin
                    fault      = 1'b1;
                    fault_code = ERR_BAD_DIM;
                  end
                end else begin
                  wr_en_n   = 1'b1;
                  wr_addr_n = cnt;
                  wr_data_n = acc;
                  if (last_elem) begin
                    done_n  = 1'b1;
                    mrow_n  = dim_r;
                    mcol_n  = dim_c;
                    state_n = DONE;
                  end else begin
                    cnt_n = cnt + 5'd1;
                  end
                end
              end
            end else begin
              fault      = 1'b1;
              fault_code = ERR_BAD_CHAR;
            end
          end
        end
        default: ;
      endcase
    end

    if (fault) begin
      state_n    = ERROR;
      error_n    = 1'b1;
      err_code_n = fault_code;
      acc_n      = 8'd0;
      pend_n     = 1'b0;
    end

    // busy stays up through the DONE/ERROR cycle and drops as IDLE is entered
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc        <= 8'd0;
      pend       <= 1'b0;
      dim_r      <= 3'd0;
      dim_c      <= 3'd0;
      cnt        <= 5'd0;
      busy       <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= 5'd0;
      wr_data    <= 8'd0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_code   <= ERR_NONE;
      matrix_row <= 3'd0;
      matrix_col <= 3'd0;
    end else begin
      state      <= state_n;
      acc        <= acc_n;
      pend       <= pend_n;
      dim_r      <= dim_r_n;
      dim_c      <= dim_c_n;
      cnt        <= cnt_n;
      busy       <= busy_n;
      wr_en      <= wr_en_n;
      wr_addr    <= wr_addr_n;
      wr_data    <= wr_data_n;
      done       <= done_n;
      error      <= error_n;
      err_code   <= err_code_n;
      matrix_row <= mrow_n;
      matrix_col <= mcol_n;
    end
  end

endmodule

// File: tb/tb_matrix_parser.sv
// Bench for matrix_parser: byte streams are scored against a token-level
// model that predicts every write/done/error pulse and the byte causing it.
module tb_matrix_parser;

  localparam int MAX_DIM = 5;

  logic       clk, rst_n, start, rx_valid;
  logic [7:0] rx_data;
  logic       busy, wr_en, done, error;
  logic [2:0] matrix_row, matrix_col, state_dbg;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic [1:0] err_code;

  matrix_parser #(.MAX_DIM(MAX_DIM)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .matrix_row(matrix_row), .matrix_col(matrix_col), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .done(done), .error(error),
    .err_code(err_code), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  // Event record: {byte index, cycles after that byte, wr_en, addr, data, done, error, code}
  logic [33:0] exp_q[$];
  logic [33:0] obs_q[$];
  int checks = 0;
  int failures = 0;

  function automatic logic [33:0] ev(input int idx, input int off, input int we, input int a,
                                      input int d, input int dn, input int er, input int code);
    return {idx[7:0], off[7:0], we[0], a[4:0], d[7:0], dn[0], er[0], code[1:0]};
  endfunction

  // ---------------- reference model (token level) ----------------
  bit m_active;
  int m_tok;
  bit m_have;
  int m_fields[$];
  int m_row, m_col, m_code;

  function automatic void model_start();
    m_active = 1; m_tok = 0; m_have = 0; m_fields.delete(); m_code = 0;
  endfunction

  function automatic void model_fail(input int code, input int idx);
    m_active = 0;
    m_code   = code;
    exp_q.push_back(ev(idx, 1, 0, 0, 0, 0, 1, code));
  endfunction

  function automatic void model_byte(input logic [7:0] b, input int idx);
    int n, e;
    if (!m_active) return;
    if (b >= 8'h30 && b <= 8'h39) begin
      m_tok  = m_tok * 10 + int'(b - 8'h30);
      m_have = 1;
      if (m_tok > 255) model_fail(3, idx);
    end else if (b == 8'h20 || b == 8'h0D || b == 8'h0A) begin
      if (!m_have) return;
      m_fields.push_back(m_tok);
      m_tok = 0; m_have = 0;
      n = m_fields.size();
      if (n <= 2) begin
        if (m_fields[n-1] < 1 || m_fields[n-1] > MAX_DIM) model_fail(2, idx);
      end else begin
        e = n - 3;
        if (e == m_fields[0] * m_fields[1] - 1) begin
          exp_q.push_back(ev(idx, 1, 1, e, m_fields[n-1], 1, 0, 0));
          m_row = m_fields[0]; m_col = m_fields[1]; m_active = 0;
        end else begin
          exp_q.push_back(ev(idx, 1, 1, e, m_fields[n-1], 0, 0, 0));
        end
      end
    end else begin
      model_fail(1, idx);
    end
  endfunction

  // ---------------- driver tasks ----------------
  int bi = 0;
  int drv_last = 255;
  int drv_since = 0;

  task automatic sample();
    @(posedge clk); #1;
    drv_since++;
    if (wr_en || done || error)
      obs_q.push_back(ev(drv_last, drv_since, int'(wr_en), wr_en ? int'(wr_addr) : 0,
                         wr_en ? int'(wr_data) : 0, int'(done), int'(error), int'(err_code)));
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    model_byte(b, bi);
    rx_data = b; rx_valid = 1'b1;
    drv_last = bi; drv_since = 0;
    sample();
    rx_valid = 1'b0;
    repeat (gap) sample();
    bi++;
  endtask

  task automatic send_str(input string s, input int gap_max);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], $urandom_range(0, gap_max));
  endtask

  task automatic do_start(input bit with_byte, input logic [7:0] b);
    model_start();
    start = 1'b1; rx_valid = with_byte; rx_data = b;
    drv_last = 255; drv_since = 0;
    sample();
    start = 1'b0; rx_valid = 1'b0;
  endtask

  task automatic tail();
    repeat (4) sample();
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic string sep();
    case ($urandom_range(0, 2))
      0: return " ";
      1: return "\r";
      default: return "\n";
    endcase
  endfunction

  function automatic string num(input int v);
    string t;
    t = $sformatf("%0d", v);
    if ($urandom_range(0, 4) == 0) t = {"0", t};
    return t;
  endfunction

  function automatic string badc();
    case ($urandom_range(0, 3))
      0: return "x";
      1: return "-";
      2: return ".";
      default: return "A";
    endcase
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    m_active = 0; m_row = 0; m_col = 0; m_code = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, wr_en, wr_addr, wr_data, done, error, err_code, matrix_row, matrix_col} !== 28'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0",
               {busy, wr_en, wr_addr, wr_data, done, error, err_code, matrix_row, matrix_col});
    end
    rst_n = 1'b1;
    exp_q.delete(); obs_q.delete();
    send_str("1 1 5 ", 0);
    tail();
    checks++;
    if (obs_q.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle_ignores got=%0d events busy=%b want=0 events busy=0", obs_q.size(), busy);
    end
  endtask

  task automatic test_basic();
    logic [33:0] o, e;
    exp_q.delete(); obs_q.delete();
    do_start(0, 8'h00);
    send_str("2 3 1 2 3 4 5 6\n", 2);
    tail();
    checks++;
    if (obs_q.size() != 6) begin
      failures++;
      $display("FAIL basic_writes got=%0d want=6", obs_q.size());
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL basic_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL basic_event got=%h want=%h", o, e); end
    end
    checks++;
    if ({matrix_row, matrix_col, busy} !== {3'd2, 3'd3, 1'b0}) begin
      failures++;
      $display("FAIL basic_dims got=%0d/%0d busy=%b want=2/3 busy=0", matrix_row, matrix_col, busy);
    end
  endtask

  task automatic test_boundary();
    logic [33:0] o, e;
    exp_q.delete(); obs_q.delete();
    do_start(0, 8'h00);
    send_str("  1  1  255 ", 1);
    tail();
    do_start(0, 8'h00);
    send_str("1 1 256 ", 1);
    tail();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL boundary_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL boundary_event got=%h want=%h", o, e); end
    end
    checks++;
    if ({wr_data, err_code, matrix_row, matrix_col} !== {8'hFF, 2'd3, 3'd1, 3'd1}) begin
      failures++;
      $display("FAIL boundary_state got=data %h code %0d dims %0d/%0d want=data ff code 3 dims 1/1",
               wr_data, err_code, matrix_row, matrix_col);
    end
  endtask

  task automatic test_bad_dim();
    logic [33:0] o, e;
    string cases[3] = '{"0 ", "6 ", "2 6 "};
    for (int k = 0; k < 3; k++) begin
      exp_q.delete(); obs_q.delete();
      do_start(0, 8'h00);
      send_str(cases[k], 1);
      tail();
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        failures++;
        $display("FAIL bad_dim_count case=%0d got=%0d want=%0d", k, obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
        o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
        if (o !== e) begin failures++; $display("FAIL bad_dim_event case=%0d got=%h want=%h", k, o, e); end
      end
      checks++;
      if (err_code !== 2'd2 || busy !== 1'b0) begin
        failures++;
        $display("FAIL bad_dim_code case=%0d got=%0d busy=%b want=2 busy=0", k, err_code, busy);
      end
    end
  endtask

  task automatic test_bad_char();
    logic [33:0] o, e;
    exp_q.delete(); obs_q.delete();
    do_start(0, 8'h00);
    send_str("2 x3 4 5 6 ", 1);
    tail();
    checks++;
    if (obs_q.size() != 1) begin
      failures++;
      $display("FAIL bad_char_events got=%0d want=1", obs_q.size());
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL bad_char_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL bad_char_event got=%h want=%h", o, e); end
    end
    checks++;
    if (err_code !== 2'd1) begin
      failures++;
      $display("FAIL bad_char_code got=%0d want=1", err_code);
    end
  endtask

  task automatic test_restart();
    logic [33:0] o, e;
    exp_q.delete(); obs_q.delete();
    do_start(0, 8'h00);
    send_str("2 2 7 8 ", 1);
    do_start(0, 8'h00);
    send_str("1 2 3 4 ", 1);
    tail();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL restart_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL restart_event got=%h want=%h", o, e); end
    end
    checks++;
    if ({matrix_row, matrix_col, err_code} !== {3'd1, 3'd2, 2'd0}) begin
      failures++;
      $display("FAIL restart_dims got=%0d/%0d code %0d want=1/2 code 0", matrix_row, matrix_col, err_code);
    end
  endtask

  task automatic test_start_collision();
    logic [33:0] o, e;
    exp_q.delete(); obs_q.delete();
    do_start(0, 8'h00);
    send_str("3 3 1 ", 0);
    do_start(1, 8'h39);
    send_str("1 1 4 ", 0);
    tail();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL collision_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL collision_event got=%h want=%h", o, e); end
    end
    checks++;
    if ({matrix_row, matrix_col, err_code} !== {3'd1, 3'd1, 2'd0}) begin
      failures++;
      $display("FAIL collision_dims got=%0d/%0d code %0d want=1/1 code 0", matrix_row, matrix_col, err_code);
    end
  endtask

  task automatic test_random();
    logic [33:0] o, e;
    int r, c, rv, cv, fault, pick, v;
    string s;
    for (int it = 0; it < 30; it++) begin
      exp_q.delete(); obs_q.delete();
      r = $urandom_range(1, MAX_DIM); c = $urandom_range(1, MAX_DIM);
      fault = $urandom_range(0, 6);
      rv = r; cv = c;
      if (fault == 3) begin
        v = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_DIM + 1, 9);
        if ($urandom_range(0, 1) == 0) rv = v; else cv = v;
      end
      s = ($urandom_range(0, 1) == 0) ? sep() : "";
      s = {s, num(rv), sep(), num(cv), sep()};
      pick = $urandom_range(0, r * c - 1);
      for (int k = 0; k < r * c; k++) begin
        if (!(fault == 6 && k == r * c - 1)) begin
          if (fault == 5 && k == pick) s = {s, badc()};
          v = (fault == 4 && k == pick) ? $urandom_range(256, 999) : $urandom_range(0, 255);
          s = {s, num(v), sep()};
          if ($urandom_range(0, 3) == 0) s = {s, sep()};
        end
      end
      if (fault == 6) s = {s, "\n"};
      do_start(0, 8'h00);
      send_str(s, 2);
      tail();
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        failures++;
        $display("FAIL random_count it=%0d got=%0d want=%0d", it, obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
        o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
        if (o !== e) begin failures++; $display("FAIL random_event it=%0d got=%h want=%h", it, o, e); end
      end
      checks++;
      if (busy !== m_active || int'(err_code) != m_code || int'(matrix_row) != m_row || int'(matrix_col) != m_col) begin
        failures++;
        $display("FAIL random_state it=%0d got=busy %b code %0d dims %0d/%0d want=busy %b code %0d dims %0d/%0d",
                 it, busy, err_code, matrix_row, matrix_col, m_active, m_code, m_row, m_col);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [33:0] o, e;
    exp_q.delete(); obs_q.delete();
    do_start(0, 8'h00);
    send_str("2 2 5 1", 0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, wr_en, wr_addr, wr_data, done, error, err_code, matrix_row, matrix_col} !== 28'd0) begin
      failures++;
      $display("FAIL reset_mid_outputs got=%h want=0",
               {busy, wr_en, wr_addr, wr_data, done, error, err_code, matrix_row, matrix_col});
    end
    m_active = 0; m_row = 0; m_col = 0; m_code = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_str(" 2 3 4 ", 1);
    tail();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL reset_mid_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL reset_mid_event got=%h want=%h", o, e); end
    end
    checks++;
    if ({busy, matrix_row, matrix_col} !== 7'd0) begin
      failures++;
      $display("FAIL reset_mid_after got=busy %b dims %0d/%0d want=busy 0 dims 0/0", busy, matrix_row, matrix_col);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_bad_dim();
    test_bad_char();
    test_restart();
    test_start_collision();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
